// File: rtl/oam_line_eval.sv
// Object attribute memory with a double-buffered (shadow/active) table and per-line object scan.
// Optional readback port of the shadow table: define OAM_READBACK_EN.
module oam_line_eval #(
    parameter int  NUM_OBJ  = 8,
    parameter int  SPRITE_H = 32,
    localparam int IDX_W    = $clog2(NUM_OBJ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic [9:0]       next_y,
`ifdef OAM_READBACK_EN
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data,
`endif
    output logic [31:0]      oam_data,
    output logic             obj_hit,
    output logic             overflow,
    output logic             eval_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        EVAL,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [9:0]       r_y;
    logic             r_commit_pend;
    logic             r_eval_pend;
    logic             r_found;
    logic             r_ovf;
    logic [31:0]      r_win;
    logic [31:0]      r_oam_data;
    logic             r_obj_hit;
    logic             r_overflow;
    logic             r_eval_done;
    logic [31:0]      r_shadow [NUM_OBJ];
    logic [31:0]      r_active [NUM_OBJ];

    logic [31:0]      w_entry;
    logic [10:0]      w_pos_y;
    logic [10:0]      w_line_y;
    logic             w_hit;
    logic             w_last;
    logic             w_commit_req;
    logic             w_eval_req;
    logic             w_found_n;
    logic             w_ovf_n;
    logic [31:0]      w_win_n;

    // 11-bit compare so objects near the bottom of the 10-bit range do not wrap.
    assign w_entry   = r_active[r_idx];
    assign w_pos_y   = {1'b0, w_entry[17:8]};
    assign w_line_y  = {1'b0, r_y};
    assign w_hit     = w_entry[28] && (w_pos_y <= w_line_y)
                       && (w_line_y < (w_pos_y + 11'(SPRITE_H)));
    assign w_last    = (r_idx == LAST_IDX);
    assign w_found_n = r_found | w_hit;
    assign w_ovf_n   = r_ovf | (r_found & w_hit);
    assign w_win_n   = (!r_found && w_hit) ? w_entry : r_win;

    assign w_commit_req = r_commit_pend | frame_start;
    assign w_eval_req   = r_eval_pend | line_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) r_shadow[i] <= '0;
        end else if (wr_en) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_y           <= '0;
            r_commit_pend <= 1'b0;
            r_eval_pend   <= 1'b0;
            r_found       <= 1'b0;
            r_ovf         <= 1'b0;
            r_win         <= '0;
            r_oam_data    <= '0;
            r_obj_hit     <= 1'b0;
            r_overflow    <= 1'b0;
            r_eval_done   <= 1'b0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) r_active[i] <= '0;
        end else begin
            r_eval_done <= 1'b0;
            if (line_start) r_y <= next_y;

            unique case (r_state)
                IDLE, DONE: begin
                    r_idx <= '0;
                    if (w_commit_req) begin
                        r_state       <= COMMIT;
                        r_commit_pend <= 1'b0;
                        r_eval_pend   <= w_eval_req;
                    end else if (w_eval_req) begin
                        r_state     <= EVAL;
                        r_eval_pend <= 1'b0;
                        r_found     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_win       <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                COMMIT: begin
                    // Copy reads the pre-edge shadow, so a same-cycle write lands next frame.
                    r_active[r_idx] <= r_shadow[r_idx];
                    if (line_start) r_eval_pend <= 1'b1;
                    if (w_last) begin
                        r_idx <= '0;
                        if (w_eval_req) begin
                            r_state     <= EVAL;
                            r_eval_pend <= 1'b0;
                            r_found     <= 1'b0;
                            r_ovf       <= 1'b0;
                            r_win       <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                EVAL: begin
                    if (frame_start) r_commit_pend <= 1'b1;
                    if (line_start) begin
                        r_idx   <= '0;
                        r_found <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_win   <= '0;
                    end else if (w_last) begin
                        // Results of the final entry go straight to the outputs on entry to DONE.
                        r_state     <= DONE;
                        r_idx       <= '0;
                        r_found     <= w_found_n;
                        r_ovf       <= w_ovf_n;
                        r_win       <= w_win_n;
                        r_oam_data  <= w_win_n;
                        r_obj_hit   <= w_found_n;
                        r_overflow  <= w_ovf_n;
                        r_eval_done <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_found <= w_found_n;
                        r_ovf   <= w_ovf_n;
                        r_win   <= w_win_n;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef OAM_READBACK_EN
    logic [31:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= r_shadow[rd_addr];
    end

    assign rd_data = r_rd_data;
`endif

    assign oam_data  = r_oam_data;
    assign obj_hit   = r_obj_hit;
    assign overflow  = r_overflow;
    assign eval_done = r_eval_done;
    assign busy      = (r_state != IDLE);

endmodule
